// File: rtl/saturn_bus_pkg.sv
// saturn_bus_pkg: Saturn bus command codes shared by the CPU and all slaves,
// plus the slave decode state type and a nibble-insert helper.
package saturn_bus_pkg;

  localparam int PTR_W = 20;

  localparam logic [3:0] BUSCMD_PC_READ     = 4'h0;
  localparam logic [3:0] BUSCMD_DP_WRITE    = 4'h1;
  localparam logic [3:0] BUSCMD_DP_READ     = 4'h2;
  localparam logic [3:0] BUSCMD_PC_WRITE    = 4'h3;
  localparam logic [3:0] BUSCMD_LOAD_PC     = 4'h4;
  localparam logic [3:0] BUSCMD_LOAD_DP     = 4'h5;
  localparam logic [3:0] BUSCMD_CONFIGURE   = 4'h6;
  localparam logic [3:0] BUSCMD_UNCONFIGURE = 4'h7;
  localparam logic [3:0] BUSCMD_POLL        = 4'h8;
  localparam logic [3:0] BUSCMD_RESET       = 4'hA;
  localparam logic [3:0] BUSCMD_NOP         = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_PC,
    ST_LOAD_DP,
    ST_CONFIG,
    ST_PC_READ,
    ST_DP_READ,
    ST_PC_WRITE,
    ST_DP_WRITE
  } bus_state_t;

  // Any code without data semantics (NOP, POLL, RESET, ...) idles.
  function automatic bus_state_t state_of(input logic [3:0] cmd);
    bus_state_t s;
    unique case (cmd)
      BUSCMD_PC_READ:   s = ST_PC_READ;
      BUSCMD_DP_READ:   s = ST_DP_READ;
      BUSCMD_PC_WRITE:  s = ST_PC_WRITE;
      BUSCMD_DP_WRITE:  s = ST_DP_WRITE;
      BUSCMD_LOAD_PC:   s = ST_LOAD_PC;
      BUSCMD_LOAD_DP:   s = ST_LOAD_DP;
      BUSCMD_CONFIGURE: s = ST_CONFIG;
      default:          s = ST_IDLE;
    endcase
    return s;
  endfunction

  // Replace nibble p of a 20-bit address; p beyond 4 leaves it intact.
  function automatic logic [PTR_W-1:0] put_nib(
    input logic [PTR_W-1:0] v,
    input logic [2:0]       p,
    input logic [3:0]       n
  );
    logic [PTR_W-1:0] r;
    r = v;
    case (p)
      3'd0:    r[3:0]   = n;
      3'd1:    r[7:4]   = n;
      3'd2:    r[11:8]  = n;
      3'd3:    r[15:12] = n;
      3'd4:    r[19:16] = n;
      default: r = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/saturn_bus_mem_array.sv
// saturn_bus_mem_array: nibble storage with one registered read port
// and one write port; write port is inert for ROM builds.
module saturn_bus_mem_array #(
  parameter int    ADDR_BITS = 13,
  parameter int    WRITABLE  = 0,
  parameter string INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [3:0]           rdata,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [3:0]           wdata
);

  logic [3:0] mem [0:(1<<ADDR_BITS)-1];

  // Write port, gated off entirely when the instance is ROM.
  always_ff @(posedge clk) begin
    if (we && (WRITABLE != 0)) mem[waddr] <= wdata;
  end

  // Read register holds its value between hits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/saturn_bus_mem.sv
// saturn_bus_mem: relocatable nibble memory slave on the Saturn bus.
// Private PC/DP pointers, command decode and base-window compare.
module saturn_bus_mem
  import saturn_bus_pkg::*;
#(
  parameter int          ADDR_BITS    = 13,
  parameter int          WRITABLE     = 0,
  parameter int          NEEDS_CONFIG = 0,
  parameter logic [19:0] BASE_DEFAULT = 20'h00000,
  parameter string       INIT_FILE    = ""
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_clk_en,
  input  logic        i_bus_clk_en,
  input  logic        i_bus_is_data,
  input  logic [3:0]  i_bus_nibble_in,
  output logic [3:0]  o_bus_nibble_out,
  output logic        o_bus_drive,
  output logic        o_configured,
  output logic [19:0] o_base
);

  logic                 strobe;
  logic                 cmd_stb;
  logic                 dat_stb;
  logic [3:0]           last_cmd;
  logic [2:0]           pos;
  logic [PTR_W-1:0]     pc;
  logic [PTR_W-1:0]     dp;
  logic [PTR_W-1:0]     base;
  logic [PTR_W-1:0]     shadow;
  logic                 configured;
  bus_state_t           state;
  logic                 use_pc;
  logic                 is_read;
  logic                 is_write;
  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     offset;
  logic                 hit;
  logic                 rd_hit;
  logic                 wr_hit;
  logic [ADDR_BITS-1:0] addr;

  assign strobe  = i_clk_en && i_bus_clk_en;
  assign cmd_stb = strobe && !i_bus_is_data;
  assign dat_stb = strobe && i_bus_is_data;

  assign state    = state_of(last_cmd);
  assign use_pc   = (state == ST_PC_READ) || (state == ST_PC_WRITE);
  assign is_read  = (state == ST_PC_READ) || (state == ST_DP_READ);
  assign is_write = (state == ST_PC_WRITE) || (state == ST_DP_WRITE);

  // Modular offset makes the window wrap across 0xFFFFF -> 0x00000.
  assign ptr    = use_pc ? pc : dp;
  assign offset = ptr - base;
  assign hit    = configured && ((offset >> ADDR_BITS) == 20'd0);
  assign addr   = offset[ADDR_BITS-1:0];

  assign rd_hit = dat_stb && is_read && hit;
  assign wr_hit = dat_stb && is_write && hit && (WRITABLE != 0);

  assign o_configured = configured;
  assign o_base       = base;

  // Command latch, pointer loads, relocation and the drive pulse.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      last_cmd    <= 4'h0;
      pos         <= 3'd0;
      pc          <= '0;
      dp          <= '0;
      shadow      <= '0;
      base        <= BASE_DEFAULT;
      configured  <= (NEEDS_CONFIG == 0);
      o_bus_drive <= 1'b0;
    end else begin
      o_bus_drive <= 1'b0;
      if (cmd_stb) begin
        last_cmd <= i_bus_nibble_in;
        if (i_bus_nibble_in == BUSCMD_LOAD_PC ||
            i_bus_nibble_in == BUSCMD_LOAD_DP ||
            i_bus_nibble_in == BUSCMD_CONFIGURE) begin
          pos <= 3'd0;
        end
        if (i_bus_nibble_in == BUSCMD_RESET) begin
          base       <= BASE_DEFAULT;
          configured <= (NEEDS_CONFIG == 0);
        end
      end else if (dat_stb) begin
        case (state)
          ST_LOAD_PC: begin
            pc  <= put_nib(pc, pos, i_bus_nibble_in);
            pos <= pos + 3'd1;
            if (pos == 3'd4) last_cmd <= BUSCMD_PC_READ;
          end
          ST_LOAD_DP: begin
            dp  <= put_nib(dp, pos, i_bus_nibble_in);
            pos <= pos + 3'd1;
            if (pos == 3'd4) last_cmd <= BUSCMD_DP_READ;
          end
          ST_CONFIG: begin
            shadow <= put_nib(shadow, pos, i_bus_nibble_in);
            pos    <= pos + 3'd1;
            if (pos == 3'd4) begin
              base       <= put_nib(shadow, pos, i_bus_nibble_in);
              configured <= 1'b1;
              last_cmd   <= BUSCMD_NOP;
            end
          end
          ST_PC_READ, ST_DP_READ: begin
            if (use_pc) pc <= pc + 20'd1;
            else dp <= dp + 20'd1;
            o_bus_drive <= hit;
          end
          ST_PC_WRITE, ST_DP_WRITE: begin
            if (use_pc) pc <= pc + 20'd1;
            else dp <= dp + 20'd1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  saturn_bus_mem_array #(
    .ADDR_BITS (ADDR_BITS),
    .WRITABLE  (WRITABLE),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .re    (rd_hit),
    .raddr (addr),
    .rdata (o_bus_nibble_out),
    .we    (wr_hit),
    .waddr (addr),
    .wdata (i_bus_nibble_in)
  );

endmodule

// File: tb/tb_saturn_bus_mem.sv
// tb_saturn_bus_mem: three differently parametrised slaves on one bus,
// compared strobe by strobe against a behavioural bus model.
module tb_saturn_bus_mem;
  import saturn_bus_pkg::*;

  localparam int NI = 3;
  localparam int AB [NI] = '{9, 4, 2};
  localparam int WR [NI] = '{1, 0, 1};
  localparam int NC [NI] = '{0, 1, 1};
  localparam logic [19:0] BD [NI] = '{20'h00000, 20'h40000, 20'h00000};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_en = 1'b0;
  logic       bus_en = 1'b0;
  logic       is_data = 1'b0;
  logic [3:0] nib_in = 4'h0;

  logic [3:0]  out  [NI];
  logic        drv  [NI];
  logic        cfgd [NI];
  logic [19:0] base [NI];

  always #5 clk = ~clk;

  saturn_bus_mem #(
    .ADDR_BITS(AB[0]), .WRITABLE(WR[0]),
    .NEEDS_CONFIG(NC[0]), .BASE_DEFAULT(BD[0]), .INIT_FILE("")
  ) u_m0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_clk_en(clk_en),
    .i_bus_clk_en(bus_en), .i_bus_is_data(is_data),
    .i_bus_nibble_in(nib_in), .o_bus_nibble_out(out[0]),
    .o_bus_drive(drv[0]), .o_configured(cfgd[0]), .o_base(base[0])
  );

  saturn_bus_mem #(
    .ADDR_BITS(AB[1]), .WRITABLE(WR[1]),
    .NEEDS_CONFIG(NC[1]), .BASE_DEFAULT(BD[1]), .INIT_FILE("")
  ) u_m1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_clk_en(clk_en),
    .i_bus_clk_en(bus_en), .i_bus_is_data(is_data),
    .i_bus_nibble_in(nib_in), .o_bus_nibble_out(out[1]),
    .o_bus_drive(drv[1]), .o_configured(cfgd[1]), .o_base(base[1])
  );

  saturn_bus_mem #(
    .ADDR_BITS(AB[2]), .WRITABLE(WR[2]),
    .NEEDS_CONFIG(NC[2]), .BASE_DEFAULT(BD[2]), .INIT_FILE("")
  ) u_m2 (
    .i_clk(clk), .i_reset_n(rst_n), .i_clk_en(clk_en),
    .i_bus_clk_en(bus_en), .i_bus_is_data(is_data),
    .i_bus_nibble_in(nib_in), .o_bus_nibble_out(out[2]),
    .o_bus_drive(drv[2]), .o_configured(cfgd[2]), .o_base(base[2])
  );

  typedef enum {
    MD_IDLE, MD_LPC, MD_LDP, MD_CFG,
    MD_RPC, MD_RDP, MD_WPC, MD_WDP
  } mode_e;

  mode_e       md;
  int          cnt;
  logic [3:0]  cq [$];
  logic [19:0] m_pc;
  logic [19:0] m_dp;
  logic [19:0] m_base [NI];
  logic        m_cfg  [NI];
  logic [3:0]  m_out  [NI];
  logic        m_drv  [NI];
  logic [3:0]  mm [NI][512];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic mode_e mode_of(logic [3:0] c);
    case (c)
      BUSCMD_LOAD_PC:   return MD_LPC;
      BUSCMD_LOAD_DP:   return MD_LDP;
      BUSCMD_CONFIGURE: return MD_CFG;
      BUSCMD_PC_READ:   return MD_RPC;
      BUSCMD_DP_READ:   return MD_RDP;
      BUSCMD_PC_WRITE:  return MD_WPC;
      BUSCMD_DP_WRITE:  return MD_WDP;
      default:          return MD_IDLE;
    endcase
  endfunction

  task automatic model_reset();
    md = mode_of(4'h0);
    cnt = 0;
    cq.delete();
    m_pc = '0;
    m_dp = '0;
    for (int i = 0; i < NI; i++) begin
      m_base[i] = BD[i];
      m_cfg[i] = (NC[i] == 0);
      m_out[i] = 4'h0;
      m_drv[i] = 1'b0;
    end
  endtask

  task automatic model_cmd(logic [3:0] c);
    for (int i = 0; i < NI; i++) m_drv[i] = 1'b0;
    md = mode_of(c);
    if (md == MD_LPC || md == MD_LDP || md == MD_CFG) begin
      cnt = 0;
      cq.delete();
    end
    if (c == BUSCMD_RESET) begin
      for (int i = 0; i < NI; i++) begin
        m_base[i] = BD[i];
        m_cfg[i] = (NC[i] == 0);
      end
    end
  endtask

  task automatic model_data(logic [3:0] n);
    logic [19:0] a;
    logic [19:0] off;
    bit rd;
    for (int i = 0; i < NI; i++) m_drv[i] = 1'b0;
    case (md)
      MD_LPC: begin
        m_pc[cnt*4 +: 4] = n;
        cnt++;
        if (cnt == 5) md = MD_RPC;
      end
      MD_LDP: begin
        m_dp[cnt*4 +: 4] = n;
        cnt++;
        if (cnt == 5) md = MD_RDP;
      end
      MD_CFG: begin
        cq.push_back(n);
        if (cq.size() == 5) begin
          for (int i = 0; i < NI; i++) begin
            m_base[i] = {cq[4], cq[3], cq[2], cq[1], cq[0]};
            m_cfg[i] = 1'b1;
          end
          md = MD_IDLE;
        end
      end
      MD_RPC, MD_RDP, MD_WPC, MD_WDP: begin
        rd = (md == MD_RPC || md == MD_RDP);
        if (md == MD_RPC || md == MD_WPC) begin
          a = m_pc;
          m_pc = m_pc + 20'd1;
        end else begin
          a = m_dp;
          m_dp = m_dp + 20'd1;
        end
        for (int i = 0; i < NI; i++) begin
          off = a - m_base[i];
          if (m_cfg[i] && int'(off) < (1 << AB[i])) begin
            if (rd) begin
              m_out[i] = mm[i][off];
              m_drv[i] = 1'b1;
            end else if (WR[i] != 0) begin
              mm[i][off] = n;
            end
          end
        end
      end
      default: begin
      end
    endcase
  endtask

  task automatic check_all(string ctx);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s drive[%0d]", ctx, i), 32'(drv[i]), 32'(m_drv[i]));
      chk($sformatf("%s nibble[%0d]", ctx, i), 32'(out[i]), 32'(m_out[i]));
      chk($sformatf("%s configured[%0d]", ctx, i), 32'(cfgd[i]), 32'(m_cfg[i]));
      chk($sformatf("%s base[%0d]", ctx, i), 32'(base[i]), 32'(m_base[i]));
    end
  endtask

  task automatic bus(logic d, logic [3:0] n, string ctx);
    @(negedge clk);
    is_data = d;
    nib_in = n;
    clk_en = 1'b1;
    bus_en = 1'b1;
    @(posedge clk);
    #1;
    bus_en = 1'b0;
    if (d) model_data(n);
    else model_cmd(n);
    check_all(ctx);
  endtask

  task automatic cmd(logic [3:0] c, string ctx);
    bus(1'b0, c, ctx);
  endtask

  task automatic dat(logic [3:0] n, string ctx);
    bus(1'b1, n, ctx);
  endtask

  task automatic load20(logic [3:0] c, logic [19:0] v, string ctx);
    cmd(c, ctx);
    for (int k = 0; k < 5; k++) dat(v[k*4 +: 4], ctx);
  endtask

  task automatic quiet(bit gated);
    @(negedge clk);
    clk_en = !gated;
    bus_en = gated;
    is_data = 1'($urandom);
    nib_in = 4'($urandom);
    @(posedge clk);
    #1;
    bus_en = 1'b0;
    clk_en = 1'b1;
    for (int i = 0; i < NI; i++) m_drv[i] = 1'b0;
    check_all(gated ? "gated" : "idle");
  endtask

  task automatic preload();
    logic [3:0] v;
    for (int a = 0; a < (1 << AB[0]); a++) begin
      v = 4'($urandom);
      mm[0][a] = v;
      u_m0.u_array.mem[a] = v;
    end
    for (int a = 0; a < (1 << AB[1]); a++) begin
      v = 4'($urandom);
      mm[1][a] = v;
      u_m1.u_array.mem[a] = v;
    end
    for (int a = 0; a < (1 << AB[2]); a++) begin
      v = 4'($urandom);
      mm[2][a] = v;
      u_m2.u_array.mem[a] = v;
    end
  endtask

  logic [3:0] rw_cmds [4];

  initial begin
    rw_cmds = '{BUSCMD_PC_READ, BUSCMD_DP_READ,
                BUSCMD_PC_WRITE, BUSCMD_DP_WRITE};
    preload();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    load20(BUSCMD_LOAD_PC, 20'h00100, "rom load");
    repeat (3) dat(4'($urandom), "rom read");
    quiet(1'b0);
    dat(4'($urandom), "rom pc103");

    cmd(BUSCMD_DP_READ, "reloc pre");
    dat(4'($urandom), "reloc unmapped");
    load20(BUSCMD_CONFIGURE, 20'h80000, "reloc cfg");
    load20(BUSCMD_LOAD_DP, 20'h8000F, "reloc dp");
    repeat (2) dat(4'($urandom), "reloc read");

    load20(BUSCMD_LOAD_DP, 20'h80005, "wr dp");
    cmd(BUSCMD_DP_WRITE, "wr cmd");
    dat(4'hA, "wr A");
    dat(4'hB, "wr B");
    load20(BUSCMD_LOAD_DP, 20'h80005, "wr dp2");
    repeat (2) dat(4'($urandom), "wr readback");

    load20(BUSCMD_CONFIGURE, 20'hFFFFE, "wrap cfg");
    load20(BUSCMD_LOAD_PC, 20'hFFFFF, "wrap pc");
    repeat (4) dat(4'($urandom), "wrap read");

    cmd(BUSCMD_LOAD_PC, "abort");
    dat(4'h3, "abort n0");
    dat(4'h4, "abort n1");
    cmd(BUSCMD_PC_READ, "abort read");
    repeat (2) dat(4'($urandom), "abort data");

    cmd(BUSCMD_CONFIGURE, "partcfg");
    dat(4'h1, "partcfg n0");
    dat(4'h2, "partcfg n1");
    cmd(BUSCMD_PC_READ, "partcfg abort");
    cmd(BUSCMD_RESET, "reset cmd");
    quiet(1'b1);
    quiet(1'b1);

    for (int e = 0; e < 70; e++) begin
      int k;
      int r;
      logic [19:0] p;
      k = $urandom_range(0, NI - 1);
      r = $urandom_range(0, 9);
      if (r == 0) load20(BUSCMD_CONFIGURE, 20'($urandom), "rnd cfg");
      else if (r == 1) cmd(BUSCMD_RESET, "rnd reset");
      else if (r == 2) begin
        cmd(BUSCMD_LOAD_DP, "rnd part");
        dat(4'($urandom), "rnd part");
        dat(4'($urandom), "rnd part");
        cmd(4'($urandom), "rnd part");
        dat(4'($urandom), "rnd part");
      end
      p = m_base[k] + 20'($urandom_range(0, (1 << AB[k]) + 3)) - 20'd2;
      load20($urandom_range(0, 1) ? BUSCMD_LOAD_PC : BUSCMD_LOAD_DP,
             p, "rnd load");
      cmd(rw_cmds[$urandom_range(0, 3)], "rnd rw");
      repeat ($urandom_range(1, 6)) begin
        if ($urandom_range(0, 4) == 0) quiet(1'($urandom));
        else dat(4'($urandom), "rnd data");
      end
    end

    cmd(BUSCMD_RESET, "pre async");
    load20(BUSCMD_LOAD_PC, 20'h00010, "pre async");
    dat(4'($urandom), "pre async read");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    dat(4'($urandom), "post reset read");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
